// File: rtl/alu_pkg.sv
// Shared opcode encodings and controller states for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpMul  = 4'd2;
  localparam logic [3:0] OpDiv  = 4'd3;
  localparam logic [3:0] OpShl  = 4'd4;
  localparam logic [3:0] OpShr  = 4'd5;
  localparam logic [3:0] OpRol  = 4'd6;
  localparam logic [3:0] OpRor  = 4'd7;
  localparam logic [3:0] OpAnd  = 4'd8;
  localparam logic [3:0] OpOr   = 4'd9;
  localparam logic [3:0] OpNor  = 4'd10;
  localparam logic [3:0] OpNand = 4'd11;
  localparam logic [3:0] OpXor  = 4'd12;
  localparam logic [3:0] OpXnor = 4'd13;
  localparam logic [3:0] OpSlt  = 4'd14;
  localparam logic [3:0] OpSeq  = 4'd15;

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per falling edge, WIDTH edges in total.
// The start edge already performs the first iteration on the incoming operands.
module alu_div_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0] rem_in, quo_in, dvs_in, step_rem, step_quo;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    rem_in   = start_i ? '0 : rem_q;
    quo_in   = start_i ? dividend_i : quo_q;
    dvs_in   = start_i ? divisor_i : dvs_q;
    shifted  = {rem_in, quo_in[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_in};
    // Borrow out of the trial subtraction means restore the shifted remainder.
    step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    step_quo = {quo_in[WIDTH-2:0], ~diff[WIDTH]};

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d  = step_rem;
      quo_d  = step_quo;
      dvs_d  = dvs_in;
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/alu_seq_p.sv
// Handshaked parametrised ALU: single-cycle ops register on the accepting edge,
// non-zero divides run through the iterative divider and land WIDTH cycles later.
module alu_seq_p
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic               c,
  input  logic               r,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         s,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Z,
  output logic               zf,
  output logic               dz
);

  localparam int unsigned ZW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [ZW-1:0]    z_q, z_d, alu_res, xe, ye, div_z;
  logic             zf_q, zf_d, dz_q, dz_d;
  logic             accept, div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem, rol_w, ror_w;
  logic [SHW-1:0]   sh;

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk_i       (c),
    .rst_i       (r),
    .start_i     (div_start),
    .dividend_i  (X),
    .divisor_i   (Y),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign in_ready  = !div_busy && ((state_q == StIdle) || (state_q == StDone && out_ready));
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign div_z     = {div_rem, div_quo};

  always_comb begin
    xe    = {{WIDTH{1'b0}}, X};
    ye    = {{WIDTH{1'b0}}, Y};
    sh    = Y[SHW-1:0];
    // A shift by WIDTH yields zero, so a zero rotate amount falls out naturally.
    rol_w = (X << sh) | (X >> (WIDTH - 32'(sh)));
    ror_w = (X >> sh) | (X << (WIDTH - 32'(sh)));
    case (s)
      OpAdd:   alu_res = xe + ye;
      OpSub:   alu_res = xe - ye;
      OpMul:   alu_res = xe * ye;
      OpDiv:   alu_res = {X, {WIDTH{1'b1}}};
      OpShl:   alu_res = {{WIDTH{1'b0}}, X << sh};
      OpShr:   alu_res = {{WIDTH{1'b0}}, X >> sh};
      OpRol:   alu_res = {{WIDTH{1'b0}}, rol_w};
      OpRor:   alu_res = {{WIDTH{1'b0}}, ror_w};
      OpAnd:   alu_res = {{WIDTH{1'b0}}, X & Y};
      OpOr:    alu_res = {{WIDTH{1'b0}}, X | Y};
      OpNor:   alu_res = {{WIDTH{1'b0}}, ~(X | Y)};
      OpNand:  alu_res = {{WIDTH{1'b0}}, ~(X & Y)};
      OpXor:   alu_res = {{WIDTH{1'b0}}, X ^ Y};
      OpXnor:  alu_res = {{WIDTH{1'b0}}, ~(X ^ Y)};
      OpSlt:   alu_res = {{(ZW-1){1'b0}}, X < Y};
      default: alu_res = {{(ZW-1){1'b0}}, X == Y};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    zf_d      = zf_q;
    dz_d      = dz_q;
    div_start = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (s == OpDiv && Y != '0) begin
            div_start = 1'b1;
            state_d   = StDiv;
          end else begin
            z_d     = alu_res;
            zf_d    = (alu_res == '0);
            dz_d    = (s == OpDiv);
            state_d = StDone;
          end
        end else if (state_q == StDone && out_ready) begin
          state_d = StIdle;
        end
      end
      StDiv: begin
        if (div_done) begin
          z_d     = div_z;
          zf_d    = (div_z == '0);
          dz_d    = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge c or posedge r) begin
    if (r) begin
      state_q <= StIdle;
      z_q     <= '0;
      zf_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      zf_q    <= zf_d;
      dz_q    <= dz_d;
    end
  end

  assign Z  = z_q;
  assign zf = zf_q;
  assign dz = dz_q;

endmodule

// File: tb/tb_alu_seq_p.sv
// Scoreboard bench for alu_seq_p at WIDTH=16: stimulus pushes expected results,
// a monitor pops and compares on every output handshake.
module tb_alu_seq_p;
  import alu_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] z;
    logic           zf;
    logic           dz;
    int             cyc;
    string          name;
  } exp_t;

  logic           c = 1'b0;
  logic           r = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [3:0]     s = '0;
  logic [W-1:0]   X = '0;
  logic [W-1:0]   Y = '0;
  logic           in_ready, out_valid, zf, dz;
  logic [2*W-1:0] Z;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  alu_seq_p #(.WIDTH(W)) dut (
    .c         (c),
    .r         (r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .zf        (zf),
    .dz        (dz)
  );

  always #5 c = ~c;
  always @(negedge c) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a request until accepted; lat>0 also pins the cycle the result must appear.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] ez, input logic edz, input int lat,
                       input bit push, input string name);
    int   n = 0;
    exp_t e;
    @(posedge c);
    #1;
    in_valid = 1'b1;
    s = op;
    X = a;
    Y = b;
    #2;
    while (!in_ready && n < 50) begin
      @(posedge c);
      #3;
      n++;
    end
    chk({name, "_accept"}, 64'(in_ready), 64'd1);
    if (push) begin
      e.z    = ez;
      e.zf   = (ez == '0);
      e.dz   = edz;
      e.cyc  = (lat > 0) ? cyc + lat : -1;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge c);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge c);
      #3;
      n++;
    end
    chk("drain", 64'(sb.size() == 0 && !out_valid), 64'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge c);
      #3;
      if (!r && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got Z=0x%0h expected no result", Z);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_z"}, 64'(Z), 64'(e.z));
          chk({e.name, "_zf"}, 64'(zf), 64'(e.zf));
          chk({e.name, "_dz"}, 64'(dz), 64'(e.dz));
          if (e.cyc >= 0) chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic stale;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_z", 64'(Z), 64'd0);
    chk("reset_zf", 64'(zf), 64'd0);
    chk("reset_dz", 64'(dz), 64'd0);
    @(posedge c);
    #1;
    r = 1'b0;
    @(posedge c);
    #3;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back single-cycle ops, one result per cycle.
    issue(OpAdd, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 1, 1'b1, "add_carry");
    issue(OpSub, 16'd3, 16'd5, 32'hFFFF_FFFE, 1'b0, 1, 1'b1, "sub_neg");
    issue(OpMul, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1, 1'b1, "mul_max");
    idle();
    drain();

    // 100/7: quotient 14, remainder 2; requests during the divide are dropped.
    issue(OpDiv, 16'd100, 16'd7, 32'h0002_000E, 1'b0, 17, 1'b1, "div_100_7");
    repeat (5) begin
      @(posedge c);
      #1;
      in_valid = 1'b1;
      s = OpAdd;
      X = 16'd1;
      Y = 16'd1;
      #2;
      chk("div_busy_in_ready", 64'(in_ready), 64'd0);
    end
    idle();
    drain();

    issue(OpDiv, 16'h1234, 16'h0000, 32'h1234_FFFF, 1'b1, 1, 1'b1, "div_by_zero");
    issue(OpXor, 16'hAAAA, 16'hAAAA, 32'h0000_0000, 1'b0, 1, 1'b1, "xor_zero");
    idle();
    drain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(OpRol, 16'h8001, 16'h0004, 32'h0000_0018, 1'b0, 0, 1'b1, "rol_bp");
    idle();
    repeat (3) begin
      #2;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_z_held", 64'(Z), 64'h18);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge c);
      #1;
    end
    out_ready = 1'b1;
    @(posedge c);
    #3;
    chk("bp_released", 64'(out_valid), 64'd0);

    // Shift / logic / compare sweep.
    issue(OpShr, 16'h8000, 16'd15, 32'h1, 1'b0, 1, 1'b1, "shr15");
    issue(OpShl, 16'h0001, 16'd15, 32'h8000, 1'b0, 1, 1'b1, "shl15");
    issue(OpSlt, 16'd5, 16'd5, 32'h0, 1'b0, 1, 1'b1, "slt_eq");
    issue(OpSeq, 16'd5, 16'd5, 32'h1, 1'b0, 1, 1'b1, "seq_eq");
    issue(OpNand, 16'hFFFF, 16'hFFFF, 32'h0, 1'b0, 1, 1'b1, "nand_ones");
    issue(OpAnd, 16'hF0F0, 16'h3C3C, 32'h3030, 1'b0, 1, 1'b1, "and");
    issue(OpOr, 16'hF000, 16'h000F, 32'hF00F, 1'b0, 1, 1'b1, "or");
    issue(OpNor, 16'h0000, 16'h0000, 32'hFFFF, 1'b0, 1, 1'b1, "nor_zero");
    issue(OpXnor, 16'h00FF, 16'h0F0F, 32'hF00F, 1'b0, 1, 1'b1, "xnor");
    issue(OpSlt, 16'd3, 16'd5, 32'h1, 1'b0, 1, 1'b1, "slt_lt");
    issue(OpRol, 16'h1234, 16'h0010, 32'h1234, 1'b0, 1, 1'b1, "rol_masked");
    issue(OpRor, 16'h0001, 16'h0001, 32'h8000, 1'b0, 1, 1'b1, "ror1");
    idle();
    drain();

    // Reset in the middle of a divide.
    issue(OpDiv, 16'd100, 16'd7, 32'h0, 1'b0, 0, 1'b0, "div_abort");
    idle();
    repeat (3) @(posedge c);
    #1;
    r = 1'b1;
    #1;
    chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
    chk("mid_reset_z", 64'(Z), 64'd0);
    chk("mid_reset_dz", 64'(dz), 64'd0);
    @(posedge c);
    #1;
    r = 1'b0;
    @(posedge c);
    #3;
    chk("mid_reset_in_ready", 64'(in_ready), 64'd1);
    stale = 1'b0;
    repeat (25) begin
      @(posedge c);
      #3;
      if (out_valid) stale = 1'b1;
    end
    chk("no_stale_done", 64'(stale), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
